// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/debug arbiter for one sync RAM (ports: clk, i_rst, cpu_*, dbg_*, dbg_lock, mem_*)
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
  state_t state;
  logic port_dbg, last_dbg, cpu_ok, pick_dbg;
  logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
  assign cpu_ok = cpu_req & ~dbg_lock;
  assign pick_dbg = dbg_req & (~cpu_ok | ~last_dbg);
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last_dbg    <= 1'b1;
      port_dbg    <= 1'b0;
      cpu_gnt     <= 1'b0;
      dbg_gnt     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      dbg_rvalid  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: if (cpu_ok | dbg_req) begin
          state     <= ISSUE;
          port_dbg  <= pick_dbg;
          cpu_gnt   <= ~pick_dbg;
          dbg_gnt   <= pick_dbg;
          mem_en    <= 1'b1;
          mem_we    <= pick_dbg ? dbg_we : cpu_we;
          mem_addr  <= pick_dbg ? dbg_addr : cpu_addr;
          mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
        end
        ISSUE: begin
          last_dbg   <= port_dbg;
          state      <= mem_we ? IDLE : RDATA;
          cpu_rvalid <= ~mem_we & ~port_dbg;
          dbg_rvalid <= ~mem_we & port_dbg;
        end
        RDATA: begin
          state <= IDLE;
          if (port_dbg) dbg_rdata_q <= mem_rdata;
          else cpu_rdata_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
